vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13: VRAM word-address width.
REQ-002 Parameter FB_COLS, default 40: framebuffer words per row (4 px/word, 160 px).
REQ-003 Parameter FB_ROWS, default 120: framebuffer rows; each row is shown on 4 screen lines.
REQ-004 clk  in  1: single clock. All logic is rising-edge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 x, y  in  11 each: screen coordinates from the vga timing generator.
REQ-007 de  in  1: active-video enable from the timing generator, 640x480 active.
REQ-008 mem_en, mem_we  out  1 each: VRAM cycle strobe and write enable.
REQ-009 mem_addr  out  ADDR_W; mem_wdata  out  16; mem_rdata  in  16: VRAM read data, valid the cycle after a read strobe.
REQ-010 host_valid, host_we  in  1 each; host_addr  in  ADDR_W; host_wdata  in  16; host_ready  out  1.
REQ-011 host_rdata  out  16; host_rvalid  out  1.
REQ-012 pix_idx  out  4; pix_de  out  1: registered palette index and delayed de.
REQ-013 host_stall_cnt  out  16: host stall count (see Configuration).

Function
REQ-014 FSM states: S_SYNC (after reset, no valid prefetch), S_BLANK, S_ACTIVE.
REQ-015 A de falling edge (de=0, prev de=1) is a line end. The arbiter SHALL issue the group-0 prefetch in that same cycle, for next line ny = (y==479) ? 0 : y+1.
REQ-016 Transitions: SYNC->BLANK on line end; BLANK->ACTIVE on de rising; ACTIVE->BLANK on line end. If de rises in SYNC, the state SHALL stay SYNC and pix_idx SHALL be 0.
REQ-017 In ACTIVE, on each cycle with de=1 and x[3:0]==0:
  - cur_word <= next_word.
  - If g = x[9:4]+1 < FB_COLS, issue a display read for group g of row y>>2.
REQ-018 Display address = row*FB_COLS + group, computed without a multiplier.
REQ-019 Display read data SHALL be captured into next_word the cycle after the read strobe.
REQ-020 Display reads have absolute priority. host_ready SHALL be 0 (combinational) in any cycle with a display read, and 1 otherwise.
REQ-021 Host transfer occurs on host_valid & host_ready. The arbiter SHALL drive mem_en=1, mem_we=host_we and pass host_addr/host_wdata through in that cycle.
REQ-022 After a host read transfer, host_rvalid SHALL be 1 for exactly one cycle, the next cycle, with host_rdata = mem_rdata. host_rvalid SHALL stay 0 after display reads and host writes.
REQ-023 Pixel output, one-cycle latency: pix_de <= de.
  - pix_idx <= W[4p+3:4p], where p = x[3:2].
  - W = next_word when x[3:0]==0, else cur_word.
  - pix_idx <= 0 when de=0 or the state is SYNC.
REQ-024 mem_en SHALL be 0 when neither a display read nor a host transfer occurs.
REQ-025 A host request held valid across a display slot SHALL complete on the next free cycle, with the request unchanged.

Reset
REQ-026 On rst: state=SYNC; cur_word, next_word, pix_idx, host_rdata = 0; pix_de, host_rvalid, mem_en, mem_we = 0; host_stall_cnt=0.
REQ-027 Reset mid-line SHALL abort any pending display read or host read. No host_rvalid SHALL follow it.

Configuration
REQ-028 Macro VRAM_ARB_STALL_CNT_EN:
  - Defined: host_stall_cnt increments on each cycle with host_valid=1 and host_ready=0, saturating at 16'hFFFF.
  - Undefined: host_stall_cnt is constant 0 and no counter logic is generated.

Verification
REQ-029 Reset, then de falls at y=3 -> one read at addr 40 (row 1, group 0); state BLANK; host_ready=0 that cycle.
REQ-030 Active line y=8, x=0..639 -> reads at addr 81..119 on cycles x=0,16,...,608. No read at x=624. pix_idx follows nibbles LSB-first, one cycle late.
REQ-031 host_valid held with host_we=0 and addr 5 while a display slot hits -> host_ready=0 that cycle, transfer next cycle, host_rvalid=1 one cycle later with VRAM[5].
REQ-032 de falls at y=479 -> prefetch addr 0 (row 0, next frame).
REQ-033 rst asserted the cycle after a host read grant -> host_rvalid stays 0. Then de rises before any line end -> pix_idx=0 for that whole line.
REQ-034 With VRAM_ARB_STALL_CNT_EN, host_valid held high for 3 display slots -> host_stall_cnt=3. Without the macro -> 0.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter between the scanout prefetcher and a host port.
// Display reads always win; the host is held off (host_ready_o=0) during display slots.
// Each framebuffer word holds four 4-bit pixels, LSB first, and each pixel spans 4 screen
// columns, so one word covers 16 columns. Row words are prefetched one group ahead.
// Optional: define VRAM_ARB_STALL_CNT_EN to build the saturating host stall counter.
module vram_arbiter #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned FB_COLS = 40,
  parameter int unsigned FB_ROWS = 120
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [10:0]       x_i,
  input  logic [10:0]       y_i,
  input  logic              de_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  input  logic [15:0]       mem_rdata_i,
  input  logic              host_valid_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [15:0]       host_wdata_i,
  output logic              host_ready_o,
  output logic [15:0]       host_rdata_o,
  output logic              host_rvalid_o,
  output logic [3:0]        pix_idx_o,
  output logic              pix_de_o,
  output logic [15:0]       host_stall_cnt_o
);

  // Each framebuffer row is shown on 4 screen lines, so this is the last visible line.
  localparam int unsigned LastLine   = FB_ROWS * 4 - 1;
  localparam logic [31:0] FbColsBits = 32'(FB_COLS);

  typedef enum logic [1:0] {StSync, StBlank, StActive} state_e;

  state_e            state_q, state_d;
  logic              de_q;
  logic [15:0]       cur_word_q, cur_word_d;
  logic [15:0]       next_word_q, next_word_d;
  logic [15:0]       host_rdata_q, host_rdata_d;
  logic [3:0]        pix_idx_q, pix_idx_d;
  logic              pix_de_q;
  logic              disp_rd_q;
  logic              host_rd_q;

  logic              line_end, de_rise, in_active, slot_tick, disp_rd, host_xfer;
  logic [7:0]        grp;
  logic [10:0]       ny, row_line;
  logic [ADDR_W-1:0] row_ext, row_base, disp_addr;
  logic [15:0]       pix_word;
  logic [3:0]        nib;

  // Line events and the display/host decision for this cycle.
  always_comb begin
    line_end  = !de_i && de_q;
    de_rise   = de_i && !de_q;
    in_active = de_i && (state_q != StSync);
    slot_tick = in_active && (x_i[3:0] == 4'd0);
    grp       = {1'b0, x_i[10:4]} + 8'd1;
    ny        = (y_i == 11'(LastLine)) ? 11'd0 : y_i + 11'd1;
    disp_rd   = !rst_i && (line_end || (slot_tick && (32'(grp) < FB_COLS)));
    host_xfer = !rst_i && host_valid_i && !disp_rd;
  end

  // Display address: row*FB_COLS as a shift-add over the set bits of the constant.
  always_comb begin
    row_line = line_end ? ny : y_i;
    row_ext  = ADDR_W'(row_line >> 2);
    row_base = '0;
    for (int i = 0; i < 32; i++) begin
      if (FbColsBits[i]) row_base = row_base + (row_ext << i);
    end
    disp_addr = row_base + (line_end ? '0 : ADDR_W'(grp));
  end

  // VRAM bus mux; display reads take the cycle outright.
  always_comb begin
    mem_en_o    = disp_rd || host_xfer;
    mem_we_o    = host_xfer && host_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (disp_rd) begin
      mem_addr_o = disp_addr;
    end else if (host_xfer) begin
      mem_addr_o  = host_addr_i;
      mem_wdata_o = host_wdata_i;
    end
  end

  assign host_ready_o  = !disp_rd;
  // Gated by reset so a read granted just before reset never reports completion.
  assign host_rvalid_o = host_rd_q && !rst_i;
  assign host_rdata_o  = host_rvalid_o ? mem_rdata_i : host_rdata_q;
  assign pix_idx_o     = pix_idx_q;
  assign pix_de_o      = pix_de_q;

  // Line-state FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StSync:   if (line_end) state_d = StBlank;
      StBlank:  if (de_rise)  state_d = StActive;
      StActive: if (line_end) state_d = StBlank;
      default:  state_d = StSync;
    endcase
  end

  // Word pipeline and pixel selection; the group boundary pixel comes from next_word.
  always_comb begin
    cur_word_d   = slot_tick ? next_word_q : cur_word_q;
    next_word_d  = disp_rd_q ? mem_rdata_i : next_word_q;
    host_rdata_d = host_rd_q ? mem_rdata_i : host_rdata_q;
    pix_word     = (x_i[3:0] == 4'd0) ? next_word_q : cur_word_q;
    nib          = 4'd0;
    unique case (x_i[3:2])
      2'd0: nib = pix_word[3:0];
      2'd1: nib = pix_word[7:4];
      2'd2: nib = pix_word[11:8];
      2'd3: nib = pix_word[15:12];
    endcase
    pix_idx_d = in_active ? nib : 4'd0;
  end

  // State registers; reset also drops any read still in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StSync;
      de_q         <= 1'b0;
      cur_word_q   <= '0;
      next_word_q  <= '0;
      host_rdata_q <= '0;
      pix_idx_q    <= '0;
      pix_de_q     <= 1'b0;
      disp_rd_q    <= 1'b0;
      host_rd_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      de_q         <= de_i;
      cur_word_q   <= cur_word_d;
      next_word_q  <= next_word_d;
      host_rdata_q <= host_rdata_d;
      pix_idx_q    <= pix_idx_d;
      pix_de_q     <= de_i;
      disp_rd_q    <= disp_rd;
      host_rd_q    <= host_xfer && !host_we_i;
    end
  end

`ifdef VRAM_ARB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of cycles the host waited on a display slot.
  always_comb begin
    stall_d = stall_q;
    if (host_valid_i && !host_ready_o && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign host_stall_cnt_o = stall_q;
`else
  assign host_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: table vectors for line-end/host cycles, scoreboarded scanout lines,
// and hand sequences for the held host read and reset-abort cases.
module tb_vram_arbiter;

  logic        clk, rst;
  logic [10:0] x, y;
  logic        de;
  logic        mem_en, mem_we;
  logic [12:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        host_valid, host_we, host_ready, host_rvalid;
  logic [12:0] host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic [3:0]  pix_idx;
  logic        pix_de;
  logic [15:0] host_stall_cnt;

  int total = 0;
  int bad   = 0;
  int exp_stall = 0;

  vram_arbiter dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .x_i             (x),
    .y_i             (y),
    .de_i            (de),
    .mem_en_o        (mem_en),
    .mem_we_o        (mem_we),
    .mem_addr_o      (mem_addr),
    .mem_wdata_o     (mem_wdata),
    .mem_rdata_i     (mem_rdata),
    .host_valid_i    (host_valid),
    .host_we_i       (host_we),
    .host_addr_i     (host_addr),
    .host_wdata_i    (host_wdata),
    .host_ready_o    (host_ready),
    .host_rdata_o    (host_rdata),
    .host_rvalid_o   (host_rvalid),
    .pix_idx_o       (pix_idx),
    .pix_de_o        (pix_de),
    .host_stall_cnt_o(host_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM model: read data valid the cycle after the strobe.
  logic [15:0] vram [8192];

  function automatic logic [15:0] vinit(input int i);
    return 16'((i * 40503) ^ 16'h5A3C);
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      else        mem_rdata <= vram[mem_addr];
    end
  end

  typedef struct {
    logic       de;
    logic [3:0] idx;
  } pix_t;
  pix_t        pix_q[$];
  logic [15:0] rd_q[$];

  typedef struct {
    logic de; int yy; int xx; logic hv; logic hwe; int ha; logic [15:0] hwd;
    logic en; logic we; int addr; logic rdy; logic rv; logic [15:0] rd;
  } vec_t;
  vec_t vecs[9];

  function automatic vec_t mkv(input logic d, input int yy, input int xx, input logic hv,
                               input logic hwe, input int ha, input logic [15:0] hwd,
                               input logic en, input logic we, input int addr,
                               input logic rdy, input logic rv, input logic [15:0] rd);
    vec_t v;
    v.de = d; v.yy = yy; v.xx = xx; v.hv = hv; v.hwe = hwe; v.ha = ha; v.hwd = hwd;
    v.en = en; v.we = we; v.addr = addr; v.rdy = rdy; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  function automatic int exp_cnt(input int n);
`ifdef VRAM_ARB_STALL_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic chk_bus(input string tag, input logic en, input logic we, input int addr,
                         input logic rdy);
    chk({tag, " mem_en"}, int'(mem_en), int'(en));
    if (en) begin
      chk({tag, " mem_we"}, int'(mem_we), int'(we));
      chk({tag, " mem_addr"}, int'(mem_addr), addr);
    end
    chk({tag, " host_ready"}, int'(host_ready), int'(rdy));
  endtask

  task automatic drive(input logic d, input int yy, input int xx, input logic hv,
                       input logic hwe, input int ha, input logic [15:0] hwd);
    de = d; y = 11'(yy); x = 11'(xx);
    host_valid = hv; host_we = hwe; host_addr = 13'(ha); host_wdata = hwd;
  endtask

  // Advance one clock and compare the registered pixel against the scoreboard.
  task automatic step();
    pix_t e;
    @(posedge clk);
    #1;
    if (pix_q.size() > 0) begin
      e = pix_q.pop_front();
      chk("pix_de", int'(pix_de), int'(e.de));
      chk("pix_idx", int'(pix_idx), int'(e.idx));
    end
  endtask

  // One scanline at yy; optional preceding line end, host writes held through hv_last.
  task automatic run_line(input int yy, input int hv_last, input bit sync_mode);
    int          base_cur, nyy;
    logic [15:0] word;
    logic        hv, slot;
    base_cur = (yy / 4) * 40;
    if (!sync_mode) begin
      drive(1, yy - 1, 639, 0, 0, 0, 0);
      @(negedge clk); chk_bus("pre_rise", 0, 0, 0, 1); step();
      drive(0, yy - 1, 640, 0, 0, 0, 0);
      @(negedge clk); chk_bus("prefetch", 1, 0, base_cur, 0); step();
      drive(0, yy - 1, 641, 0, 0, 0, 0);
      @(negedge clk); step();
    end
    for (int xx = 0; xx < 640; xx++) begin
      hv   = (xx <= hv_last);
      slot = !sync_mode && (xx % 16 == 0) && (xx / 16 + 1 < 40);
      drive(1, yy, xx, hv, 1, 4000, 16'(xx));
      @(negedge clk);
      if (slot) begin
        chk_bus("disp", 1, 0, base_cur + xx / 16 + 1, 0);
        if (hv) exp_stall++;
      end else if (hv) begin
        chk_bus("host_wr", 1, 1, 4000, 1);
      end else begin
        chk_bus("idle", 0, 0, 0, 1);
      end
      chk("line_rvalid", int'(host_rvalid), 0);
      word = vram[base_cur + xx / 16];
      pix_q.push_back('{1'b1, sync_mode ? 4'd0 : 4'((word >> (4 * ((xx / 4) % 4))) & 16'hF)});
      step();
    end
    nyy = (yy == 479) ? 0 : yy + 1;
    drive(0, yy, 640, 0, 0, 0, 0);
    @(negedge clk); chk_bus("line_end", 1, 0, (nyy / 4) * 40, 0);
    pix_q.push_back('{1'b0, 4'd0});
    step();
    drive(0, yy, 641, 0, 0, 0, 0);
    @(negedge clk); step();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) vram[i] = vinit(i);
    mem_rdata = '0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Vectors after reset: SYNC line end at y=3, host write, y=479 wrap, host read-back.
    vecs[0] = mkv(1,   3, 639, 0, 0, 0, 16'h0,    0, 0,  0, 1, 0, 16'h0);
    vecs[1] = mkv(0,   3, 640, 0, 0, 0, 16'h0,    1, 0, 40, 0, 0, 16'h0);
    vecs[2] = mkv(0,   3, 641, 1, 1, 7, 16'hBEEF, 1, 1,  7, 1, 0, 16'h0);
    vecs[3] = mkv(0,   3, 642, 0, 0, 0, 16'h0,    0, 0,  0, 1, 0, 16'h0);
    vecs[4] = mkv(1, 479, 639, 0, 0, 0, 16'h0,    0, 0,  0, 1, 0, 16'h0);
    vecs[5] = mkv(0, 479, 640, 0, 0, 0, 16'h0,    1, 0,  0, 0, 0, 16'h0);
    vecs[6] = mkv(0, 479, 641, 1, 0, 7, 16'h0,    1, 0,  7, 1, 0, 16'h0);
    vecs[7] = mkv(0, 479, 642, 0, 0, 0, 16'h0,    0, 0,  0, 1, 1, 16'hBEEF);
    vecs[8] = mkv(0, 479, 643, 0, 0, 0, 16'h0,    0, 0,  0, 1, 0, 16'h0);

    @(negedge clk);
    chk("rst mem_en", int'(mem_en), 0);
    chk("rst rvalid", int'(host_rvalid), 0);
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst pix_idx", int'(pix_idx), 0);
    chk("rst pix_de", int'(pix_de), 0);
    chk("rst host_rdata", int'(host_rdata), 0);
    chk("rst stall", int'(host_stall_cnt), 0);
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].de, vecs[i].yy, vecs[i].xx, vecs[i].hv, vecs[i].hwe, vecs[i].ha,
            vecs[i].hwd);
      @(negedge clk);
      chk_bus($sformatf("vec%0d", i), vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].rdy);
      if (vecs[i].en && vecs[i].we) chk($sformatf("vec%0d wdata", i), int'(mem_wdata),
                                        int'(vecs[i].hwd));
      chk($sformatf("vec%0d rvalid", i), int'(host_rvalid), int'(vecs[i].rv));
      if (vecs[i].rv) chk($sformatf("vec%0d rdata", i), int'(host_rdata), int'(vecs[i].rd));
      step();
    end

    // Full line y=8 with host writes held over the first three display slots.
    run_line(8, 40, 0);
    @(negedge clk); chk("stall after line", int'(host_stall_cnt), exp_cnt(exp_stall));
    step();

    // Host read held across the line-end prefetch slot.
    drive(1, 9, 639, 0, 0, 0, 0);
    @(negedge clk); chk_bus("b_rise", 0, 0, 0, 1); step();
    drive(0, 9, 640, 1, 0, 5, 0);
    @(negedge clk); chk_bus("b_slot", 1, 0, 80, 0); exp_stall++; step();
    @(negedge clk); chk_bus("b_grant", 1, 0, 5, 1);
    chk("b_rvalid_early", int'(host_rvalid), 0);
    rd_q.push_back(vinit(5));
    step();
    drive(0, 9, 642, 0, 0, 0, 0);
    @(negedge clk);
    chk("b_rvalid", int'(host_rvalid), 1);
    if (rd_q.size() > 0) chk("b_rdata", int'(host_rdata), int'(rd_q.pop_front()));
    step();
    @(negedge clk); chk("b_rvalid_once", int'(host_rvalid), 0);
    chk("b_stall", int'(host_stall_cnt), exp_cnt(exp_stall));
    step();

    // Reset right after a host read grant, then a line with no prior line end.
    drive(0, 9, 643, 1, 0, 5, 0);
    @(negedge clk); chk_bus("c_grant", 1, 0, 5, 1); step();
    rst = 1'b1;
    drive(0, 9, 644, 0, 0, 0, 0);
    @(negedge clk);
    chk("c_rst rvalid", int'(host_rvalid), 0);
    chk("c_rst mem_en", int'(mem_en), 0);
    step();
    rst = 1'b0;
    exp_stall = 0;
    @(negedge clk);
    chk("c_post rvalid", int'(host_rvalid), 0);
    chk("c_post stall", int'(host_stall_cnt), 0);
    step();
    run_line(20, -1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
